timer16: RTL and testbench

Loadable 16-bit down-counting timer for the Hack system. It is the decrementing counterpart to the incrementer datapath: it borrow-ripples a register toward zero and signals expiry. It sits on the memory-mapped peripheral side. The CPU loads a period, starts it, and polls or samples `done` to time software loops. Optional prescaling and auto-reload give periodic ticks.

---
 rtl/timer16.sv | 92 +++++++++
 tb/tb_timer16.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer16.sv
// timer16: loadable 16-bit down-counting timer with a prescaler, optional auto-reload
// and a registered one-cycle done pulse.
module timer16 #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] in,
  input  logic        start,
  input  logic        stop,
  input  logic        auto_reload,
  output logic [15:0] count,
  output logic        running,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [15:0] PRS_LAST = 16'(PRESCALE - 1);

  state_t      state;
  logic [15:0] reload;
  logic [15:0] prs;
  logic [15:0] dec;

  // Borrow ripples up from bit 0, the decrementing mirror of the inc16 carry chain.
  always_comb begin
    logic borrow;
    borrow = 1'b1;
    dec    = '0;
    for (int i = 0; i < 16; i++) begin
      dec[i] = count[i] ^ borrow;
      borrow = borrow & ~count[i];
    end
  end

  assign running = (state == RUN);

  // Priority per edge: load, then stop, then start (from IDLE only), then the prescaled tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      prs    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count  <= in;
        reload <= in;
        prs    <= '0;
        if (in == 16'd0) begin
          state <= IDLE;
        end
      end else if (stop) begin
        state <= IDLE;
        prs   <= '0;
      end else if (start && (state == IDLE)) begin
        prs <= '0;
        if (count != 16'd0) begin
          state <= RUN;
        end else begin
          done <= 1'b1;
        end
      end else if (state == RUN) begin
        if (prs == PRS_LAST) begin
          prs <= '0;
          // Expiry: reload keeps the timer running, otherwise park at zero in IDLE.
          if (count == 16'd1) begin
            done <= 1'b1;
            if (auto_reload && (reload != 16'd0)) begin
              count <= reload;
            end else begin
              count <= '0;
              state <= IDLE;
            end
          end else if (count != 16'd0) begin
            count <= dec;
          end
        end else begin
          prs <= prs + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer16.sv
// tb_timer16: scoreboard bench for timer16 with two instances (PRESCALE 1 and 3)
// checked against a cycle-level behavioural model of the timer rules.
module tb_timer16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load0 = 1'b0, start0 = 1'b0, stop0 = 1'b0, ar0 = 1'b0;
  logic [15:0] in0 = '0;
  logic        load1 = 1'b0, start1 = 1'b0, stop1 = 1'b0, ar1 = 1'b0;
  logic [15:0] in1 = '0;
  logic [15:0] count0, count1;
  logic        running0, running1, done0, done1;

  int checks = 0;
  int failures = 0;
  int doneSeen0 = 0;
  int doneSeen1 = 0;
  bit both = 1'b1;

  typedef struct {
    int cnt;
    int rel;
    int phase;
    bit run;
    bit done;
  } mstate_t;

  typedef struct {
    logic [15:0] cnt;
    logic        run;
    logic        done;
  } exp_t;

  mstate_t m0, m1;
  exp_t q0[$];
  exp_t q1[$];

  timer16 #(.PRESCALE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load0), .in(in0), .start(start0), .stop(stop0),
    .auto_reload(ar0), .count(count0), .running(running0), .done(done0)
  );

  timer16 #(.PRESCALE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .in(in1), .start(start1), .stop(stop1),
    .auto_reload(ar1), .count(count1), .running(running1), .done(done1)
  );

  always #5 clk = ~clk;

  // Timer behaviour after one clock edge, stated directly from the operating rules.
  function automatic mstate_t modelStep(mstate_t s, bit ld, int din, bit st, bit sp, bit ar, int p);
    mstate_t n;
    n = s;
    n.done = 1'b0;
    if (ld) begin
      n.cnt = din;
      n.rel = din;
      n.phase = 0;
      if (din == 0) n.run = 1'b0;
    end else if (sp) begin
      n.run = 1'b0;
      n.phase = 0;
    end else if (st && !s.run) begin
      n.phase = 0;
      if (s.cnt != 0) n.run = 1'b1;
      else n.done = 1'b1;
    end else if (s.run) begin
      if (s.phase == p - 1) begin
        n.phase = 0;
        if (s.cnt == 1) begin
          n.done = 1'b1;
          if (ar && s.rel != 0) n.cnt = s.rel;
          else begin
            n.cnt = 0;
            n.run = 1'b0;
          end
        end else if (s.cnt > 0) begin
          n.cnt = s.cnt - 1;
        end
      end else begin
        n.phase = s.phase + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t toExp(mstate_t s);
    exp_t e;
    e.cnt = 16'(s.cnt);
    e.run = s.run;
    e.done = s.done;
    return e;
  endfunction

  task automatic checkOutput(input int dut, input string name, input exp_t e,
                             input logic [15:0] c, input logic r, input logic d);
    checks++;
    if (c !== e.cnt || r !== e.run || d !== e.done) begin
      failures++;
      $display("[TB] FAIL %s dut%0d t=%0t: got count=%h running=%b done=%b, expected count=%h running=%b done=%b",
               name, dut, $time, c, r, d, e.cnt, e.run, e.done);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, predict, then let the edge happen.
  task automatic applyStimulus(input bit ld, input logic [15:0] din, input bit st,
                               input bit sp, input bit ar);
    @(negedge clk);
    load0 = ld; in0 = din; start0 = st; stop0 = sp; ar0 = ar;
    if (both) begin
      load1 = ld; in1 = din; start1 = st; stop1 = sp; ar1 = ar;
    end else begin
      load1 = 1'b0; in1 = '0; start1 = 1'b0; stop1 = 1'b0; ar1 = 1'b0;
    end
    m0 = modelStep(m0, ld, int'(din), st, sp, ar, 1);
    m1 = modelStep(m1, load1, int'(in1), start1, stop1, ar1, 3);
    q0.push_back(toExp(m0));
    q1.push_back(toExp(m1));
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    exp_t z;
    z.cnt = '0;
    z.run = 1'b0;
    z.done = 1'b0;
    @(negedge clk);
    load0 = 1'b0; start0 = 1'b0; stop0 = 1'b0; ar0 = 1'b0; in0 = '0;
    load1 = 1'b0; start1 = 1'b0; stop1 = 1'b0; ar1 = 1'b0; in1 = '0;
    rst_n = 1'b0;
    #1;
    checkOutput(0, "async_reset", z, count0, running0, done0);
    checkOutput(1, "async_reset", z, count1, running1, done1);
    m0 = '{0, 0, 0, 1'b0, 1'b0};
    m1 = '{0, 0, 0, 1'b0, 1'b0};
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) begin
        e = q0.pop_front();
        checkOutput(0, "cycle", e, count0, running0, done0);
        if (done0 === 1'b1) doneSeen0++;
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        checkOutput(1, "cycle", e, count1, running1, done1);
        if (done1 === 1'b1) doneSeen1++;
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int d0, d1, r;
    m0 = '{0, 0, 0, 1'b0, 1'b0};
    m1 = '{0, 0, 0, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    $display("[TB] one-shot load 5");
    d0 = doneSeen0;
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(16);
    checkValue("oneshot_done_pulses", doneSeen0 - d0, 1);

    $display("[TB] auto-reload load 2");
    applyStimulus(1'b1, 16'd2, 1'b0, 1'b0, 1'b1);
    d1 = doneSeen1;
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    repeat (24) applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    checkValue("autoreload_done_pulses", doneSeen1 - d1, 4);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    idle(2);

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 16'h0123, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(5);
    doReset();
    idle(3);

    $display("[TB] start with zero count, auto-reload of zero");
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 16'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    idle(3);

    $display("[TB] stop at expiry");
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    idle(3);

    $display("[TB] load at expiry");
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 16'd7, 1'b0, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

    $display("[TB] load with start in idle");
    applyStimulus(1'b1, 16'd9, 1'b1, 1'b0, 1'b0);
    idle(2);

    $display("[TB] stop and resume");
    applyStimulus(1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(4);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    idle(20);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(8);

    $display("[TB] full-range period 0xFFFF");
    both = 1'b0;
    d0 = doneSeen0;
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(65540);
    checkValue("full_range_done_pulses", doneSeen0 - d0, 1);
    both = 1'b1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      applyStimulus(r < 6, 16'($urandom_range(0, 7)), $urandom_range(0, 99) < 15,
                    (r >= 6) && (r < 11), 1'($urandom_range(0, 1)));
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
